// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared register-index, priority-state and load-entry types
package cpu_pkg;

    localparam int CPU_DATA_W = 16;

    typedef logic [2:0] reg_idx_t;

    typedef enum logic {
        ALU_PRI = 1'b0,
        LD_PRI  = 1'b1
    } wb_pri_e;

    typedef struct packed {
        reg_idx_t              rd;
        logic [CPU_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - producer, register-file and bypass signals of the writeback arbiter
interface wb_arbiter_if import cpu_pkg::*; #(
    parameter int DATA_W   = 16,
    parameter int LQ_DEPTH = 4
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    reg_idx_t          alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    reg_idx_t          ld_rd;
    logic [DATA_W-1:0] ld_data;

    logic              wr_en;
    reg_idx_t          w_r;
    logic [DATA_W-1:0] data_in;
    logic [CW-1:0]     lq_count;

    reg_idx_t          byp_rx;
    reg_idx_t          byp_ry;
    logic              byp_x_hit;
    logic              byp_y_hit;
    logic [DATA_W-1:0] byp_x_data;
    logic [DATA_W-1:0] byp_y_data;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output ld_valid, ld_rd, ld_data,
        output byp_rx, byp_ry,
        input  alu_ready, ld_ready,
        input  wr_en, w_r, data_in, lq_count,
        input  byp_x_hit, byp_y_hit, byp_x_data, byp_y_data
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  ld_valid, ld_rd, ld_data,
        input  byp_rx, byp_ry,
        output alu_ready, ld_ready,
        output wr_en, w_r, data_in, lq_count,
        output byp_x_hit, byp_y_hit, byp_x_data, byp_y_data
    );

endinterface

// File: rtl/wb_load_fifo.sv
// rtl/wb_load_fifo.sv - load-result queue feeding the writeback arbiter
module wb_load_fifo import cpu_pkg::*; #(
    parameter int  DEPTH   = 4,
    parameter type entry_t = wb_entry_t
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  entry_t                 push_entry,
    input  logic                   pop,
    output entry_t                 pop_entry,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int             PW       = $clog2(DEPTH);
    localparam logic [PW:0]    FULL_CNT = (PW + 1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Full is taken from the registered count, so a pop never makes room for a push in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign pop_entry = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - merges ALU and queued load results onto the register-file write port
// Build option: define WB_BYPASS_EN to drive the decode bypass compare outputs.
module wb_arbiter import cpu_pkg::*; #(
    parameter int DATA_W     = 16,
    parameter int LQ_DEPTH   = 4,
    parameter int STARVE_MAX = 3
) (
    input logic         clk,
    input logic         reset,
    wb_arbiter_if.slave bus
);

    localparam int CW = $clog2(LQ_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    localparam logic [0:0]    ST_ALU     = ALU_PRI;
    localparam logic [0:0]    ST_LD      = LD_PRI;
    localparam logic [CW-1:0] LQ_FULL    = CW'(LQ_DEPTH);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef struct packed {
        reg_idx_t          rd;
        logic [DATA_W-1:0] data;
    } entry_t;

    logic [0:0]    state;
    logic [0:0]    state_n;
    logic [SW-1:0] starve_cnt;
    logic [SW-1:0] starve_n;
    logic [CW-1:0] count_n;
    logic          lq_full;
    logic          lq_empty;
    logic          push;
    logic          pop;
    logic          alu_win;
    entry_t        push_entry;
    entry_t        head;

    wb_load_fifo #(
        .DEPTH   (LQ_DEPTH),
        .entry_t (entry_t)
    ) u_load_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .pop_entry  (head),
        .full       (lq_full),
        .empty      (lq_empty),
        .count      (bus.lq_count)
    );

    assign bus.alu_ready = (state == ST_ALU);
    assign bus.ld_ready  = !lq_full;

    assign push            = bus.ld_valid && !lq_full;
    assign push_entry.rd   = bus.ld_rd;
    assign push_entry.data = bus.ld_data;

    // In LD_PRI the ALU is held off, so the head pops whenever the ALU does not win.
    assign alu_win = (state == ST_ALU) && bus.alu_valid;
    assign pop     = !lq_empty && !alu_win;

    assign count_n = bus.lq_count + CW'(push) - CW'(pop);

    always_comb begin
        starve_n = starve_cnt;
        state_n  = state;
        if (state == ST_LD) begin
            starve_n = '0;
            state_n  = ST_ALU;
        end else begin
            if (pop || lq_empty) begin
                starve_n = '0;
            end else if (alu_win) begin
                starve_n = starve_cnt + 1'b1;
            end
            // Decided on post-edge values so the load wins right after the limit is reached.
            if (starve_n == STARVE_LIM || count_n == LQ_FULL) begin
                state_n = ST_LD;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_ALU;
            starve_cnt  <= '0;
            bus.wr_en   <= 1'b0;
            bus.w_r     <= '0;
            bus.data_in <= '0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            bus.wr_en  <= alu_win || pop;
            if (alu_win) begin
                bus.w_r     <= bus.alu_rd;
                bus.data_in <= bus.alu_data;
            end else if (pop) begin
                bus.w_r     <= head.rd;
                bus.data_in <= head.data;
            end
        end
    end

`ifdef WB_BYPASS_EN
    assign bus.byp_x_hit  = bus.wr_en && (bus.w_r == bus.byp_rx);
    assign bus.byp_y_hit  = bus.wr_en && (bus.w_r == bus.byp_ry);
    assign bus.byp_x_data = bus.data_in;
    assign bus.byp_y_data = bus.data_in;
`else
    logic unused_byp;
    assign unused_byp     = ^{bus.byp_rx, bus.byp_ry};
    assign bus.byp_x_hit  = 1'b0;
    assign bus.byp_y_hit  = 1'b0;
    assign bus.byp_x_data = '0;
    assign bus.byp_y_data = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter against a queue-based model
module tb_wb_arbiter;
    import cpu_pkg::*;

    localparam int DATA_W     = 16;
    localparam int LQ_DEPTH   = 4;
    localparam int STARVE_MAX = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    wb_arbiter_if #(.DATA_W(DATA_W), .LQ_DEPTH(LQ_DEPTH)) bus ();

    wb_arbiter #(
        .DATA_W     (DATA_W),
        .LQ_DEPTH   (LQ_DEPTH),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Register file consuming the write port.
    logic [DATA_W-1:0] rf [8];
    always @(posedge clk) if (bus.wr_en) rf[bus.w_r] <= bus.data_in;

    // Reference model: a queue of pending loads, a "load's turn" flag and a count of ALU wins.
    wb_entry_t         lq [$];
    bit                ld_turn;
    int                streak;
    logic              exp_wr;
    reg_idx_t          exp_rd;
    logic [DATA_W-1:0] exp_data;

    int assertions = 0;
    int failures   = 0;

    task automatic model_clear();
        lq.delete();
        ld_turn = 1'b0;
        streak  = 0;
        exp_wr  = 1'b0;
    endtask

    task automatic set_idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.ld_valid  = 1'b0;
        bus.ld_rd     = '0;
        bus.ld_data   = '0;
    endtask

    // Checks readiness, advances one clock alongside the model, then checks the write port.
    task automatic cycle();
        logic      er_alu, er_ld, had, acc;
        logic [2:0] ec;
        wb_entry_t e;
        er_alu = !ld_turn;
        er_ld  = (lq.size() < LQ_DEPTH);
        assertions++;
        if (bus.alu_ready !== er_alu || bus.ld_ready !== er_ld) begin
            failures++;
            $display("FAIL ready: alu_ready=%b ld_ready=%b, required %b %b", bus.alu_ready, bus.ld_ready, er_alu, er_ld);
        end
        acc = bus.ld_valid && er_ld;
        had = (lq.size() != 0);
        exp_wr = 1'b0;
        if (!ld_turn && bus.alu_valid) begin
            exp_wr   = 1'b1;
            exp_rd   = bus.alu_rd;
            exp_data = bus.alu_data;
            streak   = had ? streak + 1 : 0;
        end else if (had) begin
            e        = lq.pop_front();
            exp_wr   = 1'b1;
            exp_rd   = e.rd;
            exp_data = e.data;
            streak   = 0;
        end else begin
            streak = 0;
        end
        if (acc) begin
            e.rd   = bus.ld_rd;
            e.data = bus.ld_data;
            lq.push_back(e);
        end
        if (ld_turn) begin
            ld_turn = 1'b0;
            streak  = 0;
        end else begin
            ld_turn = (streak == STARVE_MAX) || (lq.size() == LQ_DEPTH);
        end
        ec = 3'(lq.size());
        @(posedge clk);
        #1;
        assertions++;
        if (bus.wr_en !== exp_wr || bus.lq_count !== ec ||
            (exp_wr && (bus.w_r !== exp_rd || bus.data_in !== exp_data))) begin
            failures++;
            $display("FAIL write_port: wr_en=%b w_r=%0d data_in=%h lq_count=%0d, required %b %0d %h %0d",
                     bus.wr_en, bus.w_r, bus.data_in, bus.lq_count, exp_wr, exp_rd, exp_data, ec);
        end
    endtask

    task automatic test_reset();
        set_idle();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        assertions++;
        if (bus.wr_en !== 1'b0 || bus.w_r !== 3'd0 || bus.data_in !== 16'h0 || bus.lq_count !== 3'd0 ||
            bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: wr_en=%b w_r=%0d data_in=%h lq_count=%0d alu_ready=%b ld_ready=%b, required 0 0 0000 0 1 1",
                     bus.wr_en, bus.w_r, bus.data_in, bus.lq_count, bus.alu_ready, bus.ld_ready);
        end
        reset = 1'b1;
        model_clear();
        repeat (2) cycle();
    endtask

    task automatic test_reset_midstream();
        int stale;
        bus.alu_valid = 1'b1;
        bus.ld_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_rd   = 3'(i);
            bus.alu_data = DATA_W'(16'h0100 + i);
            bus.ld_rd    = 3'(i + 4);
            bus.ld_data  = DATA_W'(16'h0200 + i);
            cycle();
        end
        assertions++;
        if (bus.lq_count !== 3'd3) begin
            failures++;
            $display("FAIL midstream_fill: lq_count=%0d, required 3", bus.lq_count);
        end
        reset = 1'b0;
        #2;
        assertions++;
        if (bus.wr_en !== 1'b0 || bus.lq_count !== 3'd0 || bus.alu_ready !== 1'b1 || bus.ld_ready !== 1'b1) begin
            failures++;
            $display("FAIL midstream_reset: wr_en=%b lq_count=%0d alu_ready=%b ld_ready=%b, required 0 0 1 1",
                     bus.wr_en, bus.lq_count, bus.alu_ready, bus.ld_ready);
        end
        set_idle();
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_clear();
        stale = 0;
        repeat (4) begin
            cycle();
            if (bus.wr_en !== 1'b0) stale++;
        end
        assertions++;
        if (stale != 0) begin
            failures++;
            $display("FAIL stale_write: %0d writes after reset release, required 0", stale);
        end
    endtask

    task automatic test_alu_latency();
        set_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 3'd3;
        bus.alu_data  = 16'hBEEF;
        cycle();
        assertions++;
        if (bus.wr_en !== 1'b1 || bus.w_r !== 3'd3 || bus.data_in !== 16'hBEEF) begin
            failures++;
            $display("FAIL alu_latency: wr_en=%b w_r=%0d data_in=%h, required 1 3 beef", bus.wr_en, bus.w_r, bus.data_in);
        end
        set_idle();
        cycle();
        assertions++;
        if (rf[3] !== 16'hBEEF) begin
            failures++;
            $display("FAIL alu_capture: r3=%h, required beef", rf[3]);
        end
    endtask

    task automatic test_load_latency();
        reg_idx_t order [3];
        reg_idx_t seen [$];
        order[0] = 3'd1;
        order[1] = 3'd2;
        order[2] = 3'd4;
        set_idle();
        bus.ld_valid = 1'b1;
        bus.ld_rd    = 3'd5;
        bus.ld_data  = 16'h1234;
        cycle();
        assertions++;
        if (bus.wr_en !== 1'b0) begin
            failures++;
            $display("FAIL load_latency_early: wr_en=%b one cycle after accept, required 0", bus.wr_en);
        end
        set_idle();
        cycle();
        assertions++;
        if (bus.wr_en !== 1'b1 || bus.w_r !== 3'd5 || bus.data_in !== 16'h1234) begin
            failures++;
            $display("FAIL load_latency: wr_en=%b w_r=%0d data_in=%h, required 1 5 1234", bus.wr_en, bus.w_r, bus.data_in);
        end
        cycle();
        assertions++;
        if (rf[5] !== 16'h1234) begin
            failures++;
            $display("FAIL load_capture: r5=%h, required 1234", rf[5]);
        end
        for (int i = 0; i < 3; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_rd    = order[i];
            bus.ld_data  = DATA_W'(16'hC000 + i);
            cycle();
            if (bus.wr_en === 1'b1) seen.push_back(bus.w_r);
        end
        set_idle();
        repeat (3) begin
            cycle();
            if (bus.wr_en === 1'b1) seen.push_back(bus.w_r);
        end
        assertions++;
        if (seen.size() != 3 || seen[0] !== order[0] || seen[1] !== order[1] || seen[2] !== order[2]) begin
            failures++;
            $display("FAIL load_order: %0d writes seen, required 3 in order r1 r2 r4", seen.size());
        end
    endtask

    task automatic test_starvation();
        int n_alu;
        set_idle();
        repeat (2) cycle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 3'd0;
        bus.alu_data  = 16'h0AAA;
        bus.ld_valid  = 1'b1;
        bus.ld_rd     = 3'd7;
        bus.ld_data   = 16'hA5A5;
        cycle();
        bus.ld_valid = 1'b0;
        n_alu = 0;
        while (bus.alu_ready === 1'b1 && n_alu < 10) begin
            bus.alu_data = DATA_W'(16'h0B00 + n_alu);
            cycle();
            n_alu++;
        end
        assertions++;
        if (n_alu != STARVE_MAX) begin
            failures++;
            $display("FAIL starve_limit: %0d ALU wins before load turn, required %0d", n_alu, STARVE_MAX);
        end
        cycle();
        assertions++;
        if (bus.wr_en !== 1'b1 || bus.w_r !== 3'd7 || bus.data_in !== 16'hA5A5 || bus.alu_ready !== 1'b1) begin
            failures++;
            $display("FAIL starve_load: wr_en=%b w_r=%0d data_in=%h alu_ready=%b, required 1 7 a5a5 1",
                     bus.wr_en, bus.w_r, bus.data_in, bus.alu_ready);
        end
        bus.alu_data = 16'h0CCC;
        cycle();
        set_idle();
    endtask

    task automatic test_full_queue();
        int k, stalls, got, guard, order_err;
        bit saw_full;
        set_idle();
        repeat (2) cycle();
        k = 0; stalls = 0; got = 0; guard = 0; order_err = 0; saw_full = 1'b0;
        bus.alu_valid = 1'b1;
        while ((k < 5 || got < 5) && guard < 60) begin
            bus.alu_rd   = 3'd0;
            bus.alu_data = DATA_W'(guard);
            bus.ld_valid = (k < 5);
            bus.ld_rd    = 3'(k + 1);
            bus.ld_data  = DATA_W'(16'h5000 + k);
            if (bus.ld_ready === 1'b0 && bus.lq_count === 3'd4) saw_full = 1'b1;
            if (bus.alu_ready === 1'b0) stalls++;
            if (bus.ld_valid && bus.ld_ready === 1'b1) k++;
            cycle();
            if (bus.wr_en === 1'b1 && bus.data_in[15:12] === 4'h5) begin
                if (bus.data_in !== DATA_W'(16'h5000 + got)) order_err++;
                got++;
            end
            guard++;
        end
        set_idle();
        assertions++;
        if (guard >= 60 || !saw_full || got != 5 || order_err != 0) begin
            failures++;
            $display("FAIL full_queue: cycles=%0d saw_full=%b loads_written=%0d order_errors=%0d, required <60 1 5 0",
                     guard, saw_full, got, order_err);
        end
        assertions++;
        if (stalls != got) begin
            failures++;
            $display("FAIL full_queue_stalls: %0d ALU stall cycles, required %0d (one per load turn)", stalls, got);
        end
        repeat (2) cycle();
    endtask

    task automatic test_bypass();
        logic              ex_xh, ex_yh;
        logic [DATA_W-1:0] ex_d;
        set_idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 3'd6;
        bus.alu_data  = 16'h00FF;
        cycle();
        set_idle();
        bus.byp_rx = 3'd6;
        bus.byp_ry = 3'd2;
        #1;
`ifdef WB_BYPASS_EN
        ex_xh = 1'b1; ex_yh = 1'b0; ex_d = 16'h00FF;
`else
        ex_xh = 1'b0; ex_yh = 1'b0; ex_d = 16'h0000;
`endif
        assertions++;
        if (bus.byp_x_hit !== ex_xh || bus.byp_y_hit !== ex_yh || bus.byp_x_data !== ex_d) begin
            failures++;
            $display("FAIL bypass_r6: x_hit=%b y_hit=%b x_data=%h, required %b %b %h",
                     bus.byp_x_hit, bus.byp_y_hit, bus.byp_x_data, ex_xh, ex_yh, ex_d);
        end
        for (int i = 0; i < 24; i++) begin
            bus.alu_valid = ($urandom_range(0, 3) != 0);
            bus.alu_rd    = 3'($urandom);
            bus.alu_data  = DATA_W'($urandom);
            bus.ld_valid  = ($urandom_range(0, 1) == 1);
            bus.ld_rd     = 3'($urandom);
            bus.ld_data   = DATA_W'($urandom);
            cycle();
            bus.byp_rx = 3'($urandom);
            bus.byp_ry = (i % 2 == 0) ? exp_rd : 3'($urandom);
            #1;
`ifdef WB_BYPASS_EN
            ex_xh = exp_wr && (exp_rd == bus.byp_rx);
            ex_yh = exp_wr && (exp_rd == bus.byp_ry);
            ex_d  = exp_wr ? exp_data : bus.byp_x_data;
`else
            ex_xh = 1'b0; ex_yh = 1'b0; ex_d = 16'h0000;
`endif
            assertions++;
            if (bus.byp_x_hit !== ex_xh || bus.byp_y_hit !== ex_yh || bus.byp_x_data !== ex_d ||
                bus.byp_y_data !== ex_d) begin
                failures++;
                $display("FAIL bypass_rand: x_hit=%b y_hit=%b x_data=%h y_data=%h, required %b %b %h %h",
                         bus.byp_x_hit, bus.byp_y_hit, bus.byp_x_data, bus.byp_y_data, ex_xh, ex_yh, ex_d, ex_d);
            end
        end
        set_idle();
    endtask

    task automatic test_random();
        int pa, pl;
        for (int phase = 0; phase < 4; phase++) begin
            pa = (phase == 0) ? 90 : (phase == 1) ? 50 : (phase == 2) ? 20 : 70;
            pl = (phase == 0) ? 80 : (phase == 1) ? 50 : (phase == 2) ? 90 : 30;
            for (int i = 0; i < 100; i++) begin
                bus.alu_valid = ($urandom_range(0, 99) < pa);
                bus.alu_rd    = 3'($urandom);
                bus.alu_data  = DATA_W'($urandom);
                bus.ld_valid  = ($urandom_range(0, 99) < pl);
                bus.ld_rd     = 3'($urandom);
                bus.ld_data   = DATA_W'($urandom);
                cycle();
            end
        end
        set_idle();
        repeat (8) cycle();
    endtask

    initial begin
        set_idle();
        bus.byp_rx = '0;
        bus.byp_ry = '0;
        model_clear();
        test_reset();
        test_reset_midstream();
        test_alu_latency();
        test_load_latency();
        test_starvation();
        test_full_queue();
        test_bypass();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
